// File: rtl/spi_frame_master.sv
// SPI master: one full-duplex frame of NBYTES bytes per start, all four
// SPI modes, programmable sclk divider and inter-byte gap.
module spi_frame_master #(
    parameter int NBYTES   = 5,
    parameter int CLK_DIV  = 50,
    parameter int BYTE_GAP = 0,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] tx_bytes,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] rx_bytes,
    output logic                ss_n,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso
);
    localparam int NBITS = 8 * NBYTES;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int BW = $clog2(NBITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD, DONE} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    div_cnt, div_nx;
    logic [GW-1:0]    gap_cnt, gap_nx;
    logic [BW-1:0]    bit_cnt, bit_nx;
    logic             half, half_nx;
    logic [NBITS-1:0] tx_sh, tx_nx;
    logic [NBITS-1:0] rx_sh, rx_nx;
    logic [NBITS-1:0] rx_bytes_nx;
    logic             ss_nx, sclk_nx, mosi_nx;
    logic             div_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            half     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_bytes <= '0;
            ss_n     <= 1'b1;
            sclk     <= CPOL;
            mosi     <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            gap_cnt  <= gap_nx;
            bit_cnt  <= bit_nx;
            half     <= half_nx;
            tx_sh    <= tx_nx;
            rx_sh    <= rx_nx;
            rx_bytes <= rx_bytes_nx;
            ss_n     <= ss_nx;
            sclk     <= sclk_nx;
            mosi     <= mosi_nx;
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    // Pin values are computed for the next state so sclk/ss_n/mosi come straight from flops.
    always_comb begin
        state_nx    = state;
        div_nx      = div_cnt;
        gap_nx      = gap_cnt;
        bit_nx      = bit_cnt;
        half_nx     = half;
        tx_nx       = tx_sh;
        rx_nx       = rx_sh;
        rx_bytes_nx = rx_bytes;
        ss_nx       = ss_n;
        sclk_nx     = sclk;
        mosi_nx     = mosi;
        div_end     = (div_cnt == DIV_LAST);
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                ss_nx    = 1'b1;
                sclk_nx  = CPOL;
                mosi_nx  = 1'b0;
                if (start) begin
                    state_nx = SETUP;
                    div_nx   = '0;
                    gap_nx   = '0;
                    bit_nx   = '0;
                    half_nx  = 1'b0;
                    tx_nx    = tx_bytes;
                    rx_nx    = '0;
                    ss_nx    = 1'b0;
                    mosi_nx  = CPHA ? 1'b0 : tx_bytes[NBITS-1];
                end
            end
            SETUP: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    state_nx = XFER;
                    div_nx   = '0;
                end
            end
            XFER: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    div_nx  = '0;
                    half_nx = ~half;
                    if (!half) begin
                        sclk_nx = ~CPOL;
                        if (!CPHA) rx_nx = {rx_sh[NBITS-2:0], miso};
                        else mosi_nx = tx_sh[NBITS-1];
                    end else begin
                        sclk_nx = CPOL;
                        if (CPHA) rx_nx = {rx_sh[NBITS-2:0], miso};
                        tx_nx  = {tx_sh[NBITS-2:0], 1'b0};
                        if (!CPHA) mosi_nx = tx_sh[NBITS-2];
                        bit_nx = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state_nx = HOLD;
                        else if (bit_cnt[2:0] == 3'd7 && BYTE_GAP > 0) state_nx = GAP;
                    end
                end
            end
            GAP: begin
                gap_nx = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_nx = XFER;
                    gap_nx   = '0;
                end
            end
            HOLD: begin
                div_nx = div_cnt + 1'b1;
                if (div_end) begin
                    state_nx    = DONE;
                    div_nx      = '0;
                    rx_bytes_nx = rx_sh;
                    ss_nx       = 1'b1;
                    mosi_nx     = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: four SPI modes run in lockstep against a
// bit-stream slave model, plus a single-byte instance.
module tb_spi_frame_master;
    localparam int N    = 5;
    localparam int CD   = 2;
    localparam int GAP  = 4;
    localparam int W    = 8 * N;
    localparam int LAT  = 2*CD + 16*CD*N + GAP*(N-1) + 1;
    localparam int LAT1 = 2*1 + 16*1*1 + 0 + 1;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         start     = 1'b0;
    logic [W-1:0] tx        = '0;
    logic [W-1:0] slave_out = '0;

    always #5 clk = ~clk;

    logic         busy [4];
    logic         done [4];
    logic         ss_n [4];
    logic         sclk [4];
    logic         mosi [4];
    logic [W-1:0] rx   [4];
    wire          miso [4];
    wire [W-1:0]  cap  [4];
    wire [31:0]   gap_err  [4];
    wire [31:0]   lead_n   [4];
    wire [31:0]   tail     [4];
    wire [31:0]   idle_tog [4];

    for (genvar g = 0; g < 4; g++) begin : mode
        localparam bit POL = (g >= 2);
        localparam bit PHA = (g % 2 == 1);

        spi_frame_master #(
            .NBYTES(N), .CLK_DIV(CD), .BYTE_GAP(GAP), .CPOL(POL), .CPHA(PHA)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .tx_bytes(tx),
            .busy(busy[g]), .done(done[g]), .rx_bytes(rx[g]),
            .ss_n(ss_n[g]), .sclk(sclk[g]), .mosi(mosi[g]), .miso(miso[g])
        );

        logic         so        = 1'b0;
        logic [W-1:0] sh_out    = '0;
        logic [W-1:0] sh_in     = '0;
        logic [W-1:0] got       = '0;
        logic         prev_sclk = POL;
        logic         prev_ss   = 1'b1;
        longint       lead_t[$];
        longint       last_trail = 0;
        int           n_gap_err  = 0;
        int           n_lead     = 0;
        int           n_tail     = 0;
        int           n_idle     = 0;

        // Slave treats the frame as one W-bit stream, MSB first.
        always @(sclk[g], ss_n[g]) begin
            if (prev_ss && !ss_n[g]) begin
                sh_out = slave_out;
                sh_in  = '0;
                lead_t.delete();
                if (!PHA) so = slave_out[W-1];
            end
            if (!ss_n[g] && sclk[g] != prev_sclk) begin
                if (sclk[g] != POL) begin
                    lead_t.push_back($time);
                    if (PHA) begin
                        so     = sh_out[W-1];
                        sh_out = sh_out << 1;
                    end else begin
                        sh_in = {sh_in[W-2:0], mosi[g]};
                    end
                end else begin
                    last_trail = $time;
                    if (PHA) begin
                        sh_in = {sh_in[W-2:0], mosi[g]};
                    end else begin
                        sh_out = sh_out << 1;
                        so     = sh_out[W-1];
                    end
                end
            end
            if (prev_ss && ss_n[g] && sclk[g] != prev_sclk) n_idle++;
            if (!prev_ss && ss_n[g]) begin
                got       = sh_in;
                n_lead    = lead_t.size();
                n_gap_err = 0;
                for (int k = 0; k + 1 < lead_t.size(); k++) begin
                    longint want;
                    want = (k % 8 == 7) ? 10 * (2*CD + GAP) : 10 * 2 * CD;
                    if (lead_t[k+1] - lead_t[k] != want) n_gap_err++;
                end
                n_tail = int'(($time - last_trail) / 10);
            end
            prev_ss   = ss_n[g];
            prev_sclk = sclk[g];
        end

        assign miso[g]     = so;
        assign cap[g]      = got;
        assign gap_err[g]  = n_gap_err;
        assign lead_n[g]   = n_lead;
        assign tail[g]     = n_tail;
        assign idle_tog[g] = n_idle;
    end

    logic       start1 = 1'b0;
    logic [7:0] tx1    = 8'h5A;
    logic       busy1, done1, ss_n1, sclk1, mosi1;
    logic [7:0] rx1;

    spi_frame_master #(
        .NBYTES(1), .CLK_DIV(1), .BYTE_GAP(0), .CPOL(1'b0), .CPHA(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_bytes(tx1),
        .busy(busy1), .done(done1), .rx_bytes(rx1),
        .ss_n(ss_n1), .sclk(sclk1), .mosi(mosi1), .miso(1'b1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [W-1:0] exp_rx);
        for (int i = 0; i < 4; i++) begin
            logic pol;
            pol = (i >= 2);
            check($sformatf("%s ss_n m%0d", tag, i), ss_n[i], 1'b1);
            check($sformatf("%s sclk m%0d", tag, i), sclk[i], pol);
            check($sformatf("%s mosi m%0d", tag, i), mosi[i], 1'b0);
            check($sformatf("%s busy m%0d", tag, i), busy[i], 1'b0);
            check($sformatf("%s done m%0d", tag, i), done[i], 1'b0);
            check($sformatf("%s rx m%0d", tag, i), rx[i], exp_rx);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done[0] && lat < 4 * LAT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_frame(input string tag, input int lat,
                               input logic [W-1:0] exp_rx,
                               input logic [W-1:0] exp_cap);
        check({tag, " latency"}, lat, LAT);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s done m%0d", tag, i), done[i], 1'b1);
            check($sformatf("%s busy m%0d", tag, i), busy[i], 1'b0);
            check($sformatf("%s rx m%0d", tag, i), rx[i], exp_rx);
            check($sformatf("%s slave m%0d", tag, i), cap[i], exp_cap);
            check($sformatf("%s edges m%0d", tag, i), lead_n[i], W);
            check($sformatf("%s gap m%0d", tag, i), gap_err[i], 0);
            check($sformatf("%s tail m%0d", tag, i), tail[i], CD);
        end
    endtask

    task automatic run_frame(input string tag, input logic [W-1:0] t,
                             input logic [W-1:0] s, input logic [W-1:0] exp_rx,
                             input logic [W-1:0] exp_cap);
        int lat;
        int extra [4];
        tx = t;
        slave_out = s;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx = ~t;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s busy1 m%0d", tag, i), busy[i], 1'b1);
            extra[i] = 0;
        end
        lat = 1;
        while (!done[0] && lat < 4 * LAT) begin
            @(negedge clk);
            lat++;
            if (lat == LAT / 2) start = 1'b1;
            if (lat == LAT / 2 + 1) start = 1'b0;
        end
        check_frame(tag, lat, exp_rx, exp_cap);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done[i]) extra[i]++;
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("%s extra done m%0d", tag, i), extra[i], 0);
        check_idle({tag, " after"}, exp_rx);
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] sdata;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_cap;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        logic [W-1:0] t1, t2, s1, s2;

        vecs[0].tx    = 40'hA5_00_FF_3C_81;
        vecs[0].sdata = 40'h8B_8B_8B_12_34;
        vecs[1].tx    = '0;
        vecs[1].sdata = '1;
        vecs[2].tx    = '1;
        vecs[2].sdata = '0;
        for (int k = 3; k < 6; k++) begin
            vecs[k].tx    = W'({$urandom(), $urandom()});
            vecs[k].sdata = W'({$urandom(), $urandom()});
        end
        for (int k = 0; k < 6; k++) begin
            vecs[k].exp_rx  = vecs[k].sdata;
            vecs[k].exp_cap = vecs[k].tx;
        end

        repeat (3) @(negedge clk);
        check_idle("reset", '0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++)
            run_frame($sformatf("vec%0d", k), vecs[k].tx, vecs[k].sdata,
                      vecs[k].exp_rx, vecs[k].exp_cap);

        t1 = W'({$urandom(), $urandom()});
        t2 = W'({$urandom(), $urandom()});
        s1 = W'({$urandom(), $urandom()});
        s2 = W'({$urandom(), $urandom()});
        tx = t1;
        slave_out = s1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        tx = t2;
        wait_done(lat);
        check_frame("b2b first", lat, s1, t1);
        slave_out = s2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b restart busy m%0d", i), busy[i], 1'b1);
            check($sformatf("b2b restart ss_n m%0d", i), ss_n[i], 1'b0);
            check($sformatf("b2b restart rx m%0d", i), rx[i], s1);
        end
        start = 1'b0;
        wait_done(lat);
        check_frame("b2b second", lat, s2, t2);
        repeat (3) @(negedge clk);

        tx = W'({$urandom(), $urandom()});
        slave_out = W'({$urandom(), $urandom()});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CD + 2 * (16 * CD + GAP) + 8 * CD) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("pre-reset busy m%0d", i), busy[i], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midreset", '0);
        rst = 1'b0;
        lat = 0;
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            if (done[0] || done[1] || done[2] || done[3]) lat++;
        end
        check("midreset no done", lat, 0);

        for (int i = 0; i < 4; i++)
            check($sformatf("idle sclk toggles m%0d", i), idle_tog[i], 0);

        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("n1 latency", lat, LAT1);
        check("n1 rx", rx1, 8'hFF);
        check("n1 busy", busy1, 1'b0);
        @(negedge clk);
        check("n1 ss_n", ss_n1, 1'b1);
        check("n1 sclk", sclk1, 1'b0);
        check("n1 mosi", mosi1, 1'b0);
        check("n1 rx hold", rx1, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
